// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard unit for the MIPS pipeline.
// Tracks the destination tags of the instructions in EX and later stages.
// From those tags it produces registered per-operand forwarding selects for EX,
// a combinational load-use stall for ID, and a saturating stall-cycle counter.
module fwd_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_DEPTH  = 2,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 2),
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_is_load,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          hold,
    input  logic                          flush,
    output logic                          stall,
    output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel,
    output logic [CNT_W-1:0]              stall_count
);

    localparam logic [SEL_W-1:0] SEL_REGFILE = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_IMM     = SEL_W'(1);

    // In-flight tags: index 0 is the instruction in EX, index k is in stage k.
    logic                  tag_rw [FWD_DEPTH];
    logic                  tag_ld [FWD_DEPTH];
    logic [REG_ADDR_W-1:0] tag_rd [FWD_DEPTH];

    logic [NUM_SRC*SEL_W-1:0] sel_c;
    logic                     hit_ld_c;
    logic [REG_ADDR_W-1:0]    src_c;
    logic                     advance_c;

    // Youngest-match search per operand; the descending scan lets the youngest match win.
    always_comb begin
        sel_c    = '0;
        stall    = 1'b0;
        hit_ld_c = 1'b0;
        src_c    = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            hit_ld_c = 1'b0;
            src_c    = id_src[i*REG_ADDR_W +: REG_ADDR_W];
            if (!id_src_used[i]) begin
                sel_c[i*SEL_W +: SEL_W] = SEL_IMM;
            end else begin
                sel_c[i*SEL_W +: SEL_W] = SEL_REGFILE;
                for (int j = int'(FWD_DEPTH) - 1; j >= 0; j--) begin
                    if (id_valid && (src_c != '0) && tag_rw[j] && (tag_rd[j] == src_c)) begin
                        sel_c[i*SEL_W +: SEL_W] = SEL_W'(2 + j);
                        hit_ld_c = tag_ld[j] && ((j + 1) < int'(LOAD_STAGE));
                    end
                end
            end
            stall = stall | hit_ld_c;
        end
    end

    assign advance_c = id_valid & ~stall & ~flush;

    // Tag pipeline: shift older entries, then load ID or a bubble into EX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                tag_rw[k] <= 1'b0;
                tag_ld[k] <= 1'b0;
                tag_rd[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = 1; k < int'(FWD_DEPTH); k++) begin
                tag_rw[k] <= tag_rw[k-1];
                tag_ld[k] <= tag_ld[k-1];
                tag_rd[k] <= tag_rd[k-1];
            end
            if (advance_c) begin
                tag_rw[0] <= id_regwrite;
                tag_ld[0] <= id_is_load;
                tag_rd[0] <= id_rd;
            end else begin
                tag_rw[0] <= 1'b0;
                tag_ld[0] <= 1'b0;
                tag_rd[0] <= '0;
            end
        end
    end

    // EX-stage forwarding selects; a bubble carries all-zero selects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_fwd_sel <= '0;
        end else if (!hold) begin
            ex_fwd_sel <= advance_c ? sel_c : '0;
        end
    end

    // Saturating count of real stall cycles; a flushed ID slot does not count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (!hold && stall && !flush && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random checks of fwd_hazard_unit against an instruction-history model.
module tb_fwd_hazard_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned NS = 2;
    localparam int unsigned FD = 2;
    localparam int unsigned LS = 2;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_is_load;
    logic [NS*RW-1:0] id_src;
    logic [NS-1:0] id_src_used;
    logic          hold;
    logic          flush;
    logic          stall;
    logic [NS*SW-1:0] ex_fwd_sel;
    logic [CW-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit #(
        .REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_DEPTH(FD), .LOAD_STAGE(LS),
        .SEL_W(SW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_src(id_src),
        .id_src_used(id_src_used), .hold(hold), .flush(flush), .stall(stall),
        .ex_fwd_sel(ex_fwd_sel), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Model: the list of instructions that entered EX, newest first.
    typedef struct {
        logic          rw;
        logic          ld;
        logic [RW-1:0] rd;
    } instr_t;

    instr_t   hist [$];
    logic [NS*SW-1:0] exp_sel;
    int       exp_cnt;
    logic     exp_stall;
    logic [NS*SW-1:0] want_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [SW-1:0] sel_of(input int i);
        logic [NS*SW-1:0] v;
        v = ex_fwd_sel;
        return v[i*SW +: SW];
    endfunction

    task automatic model_reset();
        instr_t b;
        b.rw = 1'b0; b.ld = 1'b0; b.rd = '0;
        hist.delete();
        for (int d = 0; d < int'(FD); d++) hist.push_back(b);
        exp_sel = '0;
        exp_cnt = 0;
    endtask

    // A source at distance d (producer issued d cycles earlier) forwards from stage d,
    // encoded d+1; a load still in a stage before LOAD_STAGE forces a stall.
    task automatic model_eval();
        logic [RW-1:0] s;
        logic found;
        exp_stall = 1'b0;
        want_sel  = '0;
        for (int i = 0; i < int'(NS); i++) begin
            s = id_src[i*RW +: RW];
            found = 1'b0;
            if (!id_src_used[i]) begin
                want_sel[i*SW +: SW] = 2'd1;
            end else begin
                for (int d = 1; d <= int'(FD); d++) begin
                    if (!found && id_valid && s != 0 && hist[d-1].rw && hist[d-1].rd == s) begin
                        found = 1'b1;
                        want_sel[i*SW +: SW] = SW'(d + 1);
                        if (hist[d-1].ld && d < int'(LS)) exp_stall = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_clock();
        instr_t e;
        logic adv;
        if (!hold) begin
            adv = id_valid && !exp_stall && !flush;
            e.rw = adv ? id_regwrite : 1'b0;
            e.ld = adv ? id_is_load  : 1'b0;
            e.rd = adv ? id_rd       : '0;
            hist.push_front(e);
            void'(hist.pop_back());
            exp_sel = adv ? want_sel : '0;
            if (exp_stall && !flush && exp_cnt < 65535) exp_cnt++;
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic ld, input logic [RW-1:0] rd,
                         input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                         input logic [NS-1:0] used, input logic h, input logic f);
        id_valid = v; id_regwrite = rw; id_is_load = ld; id_rd = rd;
        id_src = {s1, s0}; id_src_used = used; hold = h; flush = f;
    endtask

    logic seen_stall;

    // One cycle: inputs applied just after a rising edge, stall sampled mid-cycle,
    // registered outputs sampled 1 time unit after the next rising edge.
    task automatic step(input logic v, input logic rw, input logic ld, input logic [RW-1:0] rd,
                        input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                        input logic [NS-1:0] used, input logic h, input logic f);
        drive(v, rw, ld, rd, s0, s1, used, h, f);
        #4;
        model_eval();
        seen_stall = stall;
        chk("stall", 32'(stall), 32'(exp_stall));
        @(posedge clk);
        #1;
        model_clock();
        chk("ex_fwd_sel", 32'(ex_fwd_sel), 32'(exp_sel));
        chk("stall_count", 32'(stall_count), 32'(exp_cnt));
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        #12;
        chk("rst_sel", 32'(ex_fwd_sel), 32'd0);
        chk("rst_cnt", 32'(stall_count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ALU chain: distance-1 forward from MEM, untouched rt from regfile.
        step(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd7, 2'b11, 1'b0, 1'b0);
        chk("alu_stall", 32'(seen_stall), 32'd0);
        chk("alu_sel0", 32'(sel_of(0)), 32'd2);
        chk("alu_sel1", 32'(sel_of(1)), 32'd0);

        // Distance 2 forwards from WB.
        nops(2);
        step(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("dist2_sel0", 32'(sel_of(0)), 32'd3);

        // Two writers of the same register: the younger one wins.
        nops(2);
        step(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("prio_sel0", 32'(sel_of(0)), 32'd2);

        // Register 0 never forwards.
        nops(2);
        step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("r0_sel0", 32'(sel_of(0)), 32'd0);

        // Load-use: one stall cycle with a bubble, then forward from WB.
        nops(2);
        step(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd5, 2'b11, 1'b0, 1'b0);
        chk("lu_stall", 32'(seen_stall), 32'd1);
        chk("lu_bubble", 32'(ex_fwd_sel), 32'd0);
        chk("lu_cnt", 32'(stall_count), 32'd1);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd5, 2'b11, 1'b0, 1'b0);
        chk("lu_retry_stall", 32'(seen_stall), 32'd0);
        chk("lu_sel1", 32'(sel_of(1)), 32'd3);
        chk("lu_cnt2", 32'(stall_count), 32'd1);

        // A younger ALU writer shadows the older load.
        nops(2);
        step(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("shadow_stall", 32'(seen_stall), 32'd0);
        chk("shadow_sel0", 32'(sel_of(0)), 32'd2);
        nops(2);
        step(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 2'b10, 1'b0, 1'b0);
        chk("imm_sel0", 32'(sel_of(0)), 32'd1);

        // Hold during a load-use stall freezes everything; release counts one stall.
        nops(2);
        step(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 2'b01, 1'b1, 1'b0);
            chk("hold_stall", 32'(seen_stall), 32'd1);
            chk("hold_sel", 32'(ex_fwd_sel), 32'h5);
            chk("hold_cnt", 32'(stall_count), 32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("hold_rel_stall", 32'(seen_stall), 32'd1);
        chk("hold_rel_cnt", 32'(stall_count), 32'd2);
        chk("hold_rel_sel", 32'(ex_fwd_sel), 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("hold_fwd_sel0", 32'(sel_of(0)), 32'd3);

        // Flush beats stall: bubble, no count.
        nops(2);
        step(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0, 2'b01, 1'b0, 1'b1);
        chk("flush_stall", 32'(seen_stall), 32'd1);
        chk("flush_sel", 32'(ex_fwd_sel), 32'd0);
        chk("flush_cnt", 32'(stall_count), 32'd2);

        // Asynchronous reset in the middle of a load-use stall.
        nops(2);
        step(1'b1, 1'b1, 1'b1, 5'd11, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd11, 5'd0, 2'b01, 1'b0, 1'b0);
        #3;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_sel", 32'(ex_fwd_sel), 32'd0);
        chk("arst_cnt", 32'(stall_count), 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd11, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("post_rst_stall", 32'(seen_stall), 32'd0);
        chk("post_rst_sel0", 32'(sel_of(0)), 32'd0);

        // Random traffic over a small register set to provoke frequent hazards.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 2'($urandom), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
